// File: rtl/case_3_mul_pkg.sv
// Shared definitions for the pipelined multiply / multiply-accumulate core:
// operand signedness encodings, the per-beat control tag and the output
// resize helper used by the final stage.
package case_3_mul_pkg;

  // sign_mode bit masks: a set bit marks the matching operand as signed
  localparam logic [1:0] SIGN_D0 = 2'b01;
  localparam logic [1:0] SIGN_D1 = 2'b10;

  // Working width of the resize helper; accumulator and result must fit in it
  localparam int SAT_W = 64;

  // Control tag that travels alongside each beat through the pipeline
  typedef struct packed {
    logic vld;
    logic acc_en;
    logic acc_clr;
  } beat_tag_t;

  // Resize a signed value to dout_w bits.
  // Returns {ovf, result}; only the low dout_w bits of result are meaningful.
  // ovf flags a value outside the signed dout_w range, regardless of sat_en.
  // With sat_en the result clamps to the range limit, otherwise it is src
  // unchanged and the caller keeps the low bits (wrap).
  function automatic logic [SAT_W:0] sat_resize(
    input logic signed [SAT_W-1:0] src,
    input int                      dout_w,
    input logic                    sat_en
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    logic signed [SAT_W-1:0] res;
    logic                    ovf;
    one   = {{(SAT_W-1){1'b0}}, 1'b1};
    max_v = (one <<< (dout_w - 1)) - one;
    // in two's complement the most negative value is the complement of the max
    min_v = ~max_v;
    ovf   = (src > max_v) || (src < min_v);
    res   = src;
    if (sat_en && ovf) begin
      res = src[SAT_W-1] ? min_v : max_v;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/case_3_mul_pipe_reg.sv
// Delay line of DEPTH registers, W bits wide, with clock enable and
// synchronous reset. DEPTH=0 degenerates to a plain wire so callers can
// size the pipeline purely by parameter.
module case_3_mul_pipe_reg #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, ce};
      assign q = d;
    end else begin : g_regs
      logic [W-1:0] stg [DEPTH];

      // Shift the delay line on every enabled cycle; reset empties it
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
          end
        end else if (ce) begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
          end
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/case_3_mul_mac_pipe.sv
// Pipelined multiplier / multiply-accumulator.
// Stage 1 registers the raw beat, the product is formed from the stage-1
// registers and carried through the middle stages, and the final stage
// accumulates, resizes and registers the result. Total latency is NUM_STAGE
// enabled cycles; with NUM_STAGE=1 the whole datapath is combinational into
// the output register.
module case_3_mul_mac_pipe
  import case_3_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int ACC_WIDTH  = 40,
  parameter int SAT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [1:0]            sign_mode,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int TAG_W     = $bits(beat_tag_t);
  // each operand grows by one bit so signed and unsigned share one signed multiplier
  localparam int PW        = din0_WIDTH + din1_WIDTH + 2;
  localparam int S1_W      = TAG_W + 2 + din1_WIDTH + din0_WIDTH;
  localparam int MID_W     = TAG_W + PW;
  localparam int S1_DEPTH  = (NUM_STAGE > 1) ? 1 : 0;
  localparam int MID_DEPTH = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;

  generate
    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
      $error("case_3_mul_mac_pipe: NUM_STAGE must be in 1..8");
    end
    if (ACC_WIDTH < din0_WIDTH + din1_WIDTH + 1) begin : g_bad_acc
      $error("case_3_mul_mac_pipe: ACC_WIDTH too narrow for the product");
    end
    if (ACC_WIDTH > SAT_W || dout_WIDTH > SAT_W || PW > SAT_W) begin : g_bad_wide
      $error("case_3_mul_mac_pipe: widths exceed the resize helper range");
    end
    if (ID < 0) begin : g_bad_id
      $error("case_3_mul_mac_pipe: ID must be non-negative");
    end
  endgenerate

  // ---------------------------------------------------------------- stage 1
  beat_tag_t             in_tag;
  beat_tag_t             s1_tag;
  logic [1:0]            s1_sm;
  logic [din0_WIDTH-1:0] s1_din0;
  logic [din1_WIDTH-1:0] s1_din1;
  logic [S1_W-1:0]       s1_q;

  assign in_tag = {din_vld, acc_en, acc_clr};

  case_3_mul_pipe_reg #(
    .W     (S1_W),
    .DEPTH (S1_DEPTH)
  ) u_s1 (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     ({in_tag, sign_mode, din1, din0}),
    .q     (s1_q)
  );

  assign {s1_tag, s1_sm, s1_din1, s1_din0} = s1_q;

  // ---------------------------------------------------------------- product
  logic                         op0_signed;
  logic                         op1_signed;
  logic signed [din0_WIDTH:0]   op0_x;
  logic signed [din1_WIDTH:0]   op1_x;
  logic signed [PW-1:0]         prod;

  assign op0_signed = |(s1_sm & SIGN_D0);
  assign op1_signed = |(s1_sm & SIGN_D1);
  assign op0_x      = {op0_signed & s1_din0[din0_WIDTH-1], s1_din0};
  assign op1_x      = {op1_signed & s1_din1[din1_WIDTH-1], s1_din1};
  // PW bits hold any product of the extended operands exactly
  assign prod       = PW'(op0_x) * PW'(op1_x);

  // ------------------------------------------------------- middle stages
  beat_tag_t            f_tag;
  logic signed [PW-1:0] f_prod;
  logic [MID_W-1:0]     mid_q;

  case_3_mul_pipe_reg #(
    .W     (MID_W),
    .DEPTH (MID_DEPTH)
  ) u_mid (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     ({s1_tag, prod}),
    .q     (mid_q)
  );

  assign {f_tag, f_prod} = mid_q;

  // ----------------------------------------------------------- final stage
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_acc;
  logic signed [ACC_WIDTH-1:0] src_acc;
  logic signed [SAT_W-1:0]     src_wide;
  logic [SAT_W:0]              sat_out;
  logic [dout_WIDTH-1:0]       dout_c;
  logic                        ovf_c;
  logic                        unused_sat;

  // Select the result source: running sum for a continuing MAC, else the product
  always_comb begin
    prod_acc = ACC_WIDTH'(f_prod);
    src_acc  = prod_acc;
    if (f_tag.acc_en && !f_tag.acc_clr) begin
      src_acc = acc + prod_acc;
    end
  end

  // Resize the source to the output width and flag out-of-range values
  always_comb begin
    src_wide = SAT_W'(src_acc);
    sat_out  = sat_resize(src_wide, dout_WIDTH, SAT_EN != 0);
    ovf_c    = sat_out[SAT_W];
    dout_c   = sat_out[dout_WIDTH-1:0];
  end

  // upper helper bits beyond dout_WIDTH are intentionally dropped
  assign unused_sat = ^sat_out;

  // Output and accumulator registers; only valid beats touch dout and acc
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout_vld <= f_tag.vld;
      ovf      <= f_tag.vld & ovf_c;
      if (f_tag.vld) begin
        dout <= dout_c;
        if (f_tag.acc_en) begin
          acc <= src_acc;
        end else if (f_tag.acc_clr) begin
          acc <= '0;
        end
      end
    end
  end

endmodule
